// File: rtl/core_mem_port_pkg.sv
// Shared defaults and request classification for the core data-memory port.
package core_mem_port_pkg;

  localparam int DEF_DATA_WIDTH        = 16;
  localparam int DEF_ADDR_WIDTH        = 16;
  localparam int DEF_LOCAL_MEMORY_SIZE = 2048;
  localparam int DEF_LOCAL_SELECT_BITS = 2;
  localparam int DEF_WB_DEPTH          = 4;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_LOCAL,
    ACC_EXT_WR,
    ACC_EXT_RD
  } access_e;

endpackage

// File: rtl/core_mem_port_write_buffer.sv
// Posted-write FIFO: holds {addr, data} entries until the external bus grants them.
module core_write_buffer #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq,
  input  logic             deq,
  input  logic [WIDTH-1:0] enq_data,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_enq, do_deq;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign do_enq = enq && !full;
  assign do_deq = deq && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = do_enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_enq && !do_deq)      count_d = count_q + CW'(1);
    else if (!do_enq && do_deq) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= enq_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/core_mem_port.sv
// Routes pipeline loads/stores to tightly-coupled local RAM or, through a
// posted-write buffer, to a shared external bus.
module core_mem_port
  import core_mem_port_pkg::*;
#(
  parameter int  DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int  ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int  LOCAL_MEMORY_SIZE = DEF_LOCAL_MEMORY_SIZE,
  parameter int  LOCAL_SELECT_BITS = DEF_LOCAL_SELECT_BITS,
  parameter int  WB_DEPTH          = DEF_WB_DEPTH,
  localparam int LOCAL_ADDR_WIDTH  = $clog2(LOCAL_MEMORY_SIZE),
  localparam int WB_COUNT_WIDTH    = $clog2(WB_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       daddr,
  input  logic [DATA_WIDTH-1:0]       ddata_out,
  input  logic                        dwrite_en,
  input  logic                        dread_en,
  output logic [DATA_WIDTH-1:0]       ddata_in,
  output logic                        stall,
  output logic [LOCAL_ADDR_WIDTH-1:0] local_addr,
  output logic                        local_wren,
  output logic [DATA_WIDTH-1:0]       local_wdata,
  input  logic [DATA_WIDTH-1:0]       local_q,
  output logic                        core_request,
  input  logic                        core_enable,
  output logic [ADDR_WIDTH-1:0]       memory_addr,
  output logic                        memory_wren,
  output logic                        memory_rden,
  output logic [DATA_WIDTH-1:0]       memory_write_val,
  input  logic [DATA_WIDTH-1:0]       memory_read_val,
  output logic [WB_COUNT_WIDTH-1:0]   wb_count,
  output logic                        wb_empty
);

  access_e                          acc;
  logic                             is_local;
  logic                             wb_full;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] wb_head;
  logic                             sel_local_q, sel_local_d;

  assign is_local = (daddr[ADDR_WIDTH-1 -: LOCAL_SELECT_BITS] == '0);

  // A simultaneous read and write is a write.
  always_comb begin
    acc = ACC_IDLE;
    if (dwrite_en || dread_en) begin
      if (is_local)       acc = ACC_LOCAL;
      else if (dwrite_en) acc = ACC_EXT_WR;
      else                acc = ACC_EXT_RD;
    end
  end

  core_write_buffer #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (WB_DEPTH)
  ) u_wb (
    .clk      (clk),
    .reset    (reset),
    .enq      (acc == ACC_EXT_WR),
    .deq      (core_enable),
    .enq_data ({daddr, ddata_out}),
    .head     (wb_head),
    .count    (wb_count),
    .full     (wb_full),
    .empty    (wb_empty)
  );

  assign local_addr  = daddr[LOCAL_ADDR_WIDTH-1:0];
  assign local_wren  = dwrite_en && is_local;
  assign local_wdata = ddata_out;

  // The buffer owns the bus while non-empty, so reads never overtake posted writes.
  assign memory_wren      = !reset && !wb_empty;
  assign memory_rden      = !reset && wb_empty && (acc == ACC_EXT_RD);
  assign core_request     = memory_wren || (!reset && (acc == ACC_EXT_RD));
  assign memory_addr      = wb_empty ? daddr : wb_head[DATA_WIDTH +: ADDR_WIDTH];
  assign memory_write_val = wb_head[DATA_WIDTH-1:0];

  assign stall = ((acc == ACC_EXT_WR) && wb_full) ||
                 ((acc == ACC_EXT_RD) && (!wb_empty || !core_enable));

  assign sel_local_d = is_local;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_local_q <= 1'b0;
    else       sel_local_q <= sel_local_d;
  end

  assign ddata_in = sel_local_q ? local_q : memory_read_val;

endmodule

// File: tb/tb_core_mem_port.sv
// Randomized and directed checks of core_mem_port against a queue-based model.
module tb_core_mem_port;

  localparam int WBD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] daddr, ddata_out, ddata_in;
  logic        dwrite_en, dread_en, stall;
  logic [10:0] local_addr;
  logic        local_wren;
  logic [15:0] local_wdata, local_q;
  logic        core_request, core_enable;
  logic [15:0] memory_addr, memory_write_val, memory_read_val;
  logic        memory_wren, memory_rden;
  logic [2:0]  wb_count;
  logic        wb_empty;

  always #5 clk = ~clk;

  core_mem_port dut (
    .clk(clk), .reset(reset),
    .daddr(daddr), .ddata_out(ddata_out), .dwrite_en(dwrite_en), .dread_en(dread_en),
    .ddata_in(ddata_in), .stall(stall),
    .local_addr(local_addr), .local_wren(local_wren), .local_wdata(local_wdata), .local_q(local_q),
    .core_request(core_request), .core_enable(core_enable), .memory_addr(memory_addr),
    .memory_wren(memory_wren), .memory_rden(memory_rden), .memory_write_val(memory_write_val),
    .memory_read_val(memory_read_val), .wb_count(wb_count), .wb_empty(wb_empty)
  );

  // Environment RAMs (driven by DUT outputs) and architectural model state.
  logic [15:0] env_local [int];
  logic [15:0] env_ext   [int];
  logic [15:0] m_local   [int];
  logic [15:0] m_ext     [int];
  logic [31:0] wq [$];
  logic        rd_pending;
  logic [15:0] rd_expect;
  logic        m_stall;

  int checks = 0;
  int passes = 0;

  logic        obs_stall, obs_wren, obs_rden, obs_lwren, obs_req;
  logic [2:0]  obs_count;
  logic [15:0] obs_maddr, obs_ddata;

  function automatic logic [15:0] local_init(input int a);
    return 16'(a * 3 + 1);
  endfunction

  function automatic logic [15:0] ext_init(input int a);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Starts at a falling edge, applies one cycle of stimulus, compares, and
  // ends at the next falling edge.
  task automatic do_cycle(input logic w, input logic r, input logic [15:0] a,
                          input logic [15:0] d, input logic ce);
    logic loc, ird, e_wren, e_rden, e_req, e_stall;
    logic lw, mw;
    logic [10:0] la;
    logic [15:0] lwd, ma, mv;
    int n;
    dwrite_en = w; dread_en = r; daddr = a; ddata_out = d; core_enable = ce;
    #1;
    loc     = (a[15:14] == 2'b00);
    ird     = r && !w;
    n       = wq.size();
    e_wren  = (n > 0);
    e_rden  = ird && !loc && (n == 0);
    e_req   = e_wren || (ird && !loc);
    e_stall = (w && !loc && n == WBD) || (ird && !loc && (n > 0 || !ce));
    m_stall = e_stall;

    obs_stall = stall; obs_wren = memory_wren; obs_rden = memory_rden;
    obs_lwren = local_wren; obs_req = core_request; obs_count = wb_count;
    obs_maddr = memory_addr; obs_ddata = ddata_in;

    chk("stall", stall, e_stall);
    chk("core_request", core_request, e_req);
    chk("memory_wren", memory_wren, e_wren);
    chk("memory_rden", memory_rden, e_rden);
    chk("wb_count", wb_count, n);
    chk("wb_empty", wb_empty, n == 0);
    chk("local_wren", local_wren, w && loc);
    chk("local_addr", local_addr, a[10:0]);
    chk("local_wdata", local_wdata, d);
    if (n > 0) begin
      chk("memory_addr_wr", memory_addr, wq[0][31:16]);
      chk("memory_write_val", memory_write_val, wq[0][15:0]);
    end else if (e_rden) begin
      chk("memory_addr_rd", memory_addr, a);
    end
    if (rd_pending) chk("ddata_in", ddata_in, rd_expect);

    lw = local_wren; la = local_addr; lwd = local_wdata;
    mw = memory_wren && ce; ma = memory_addr; mv = memory_write_val;

    rd_pending = 1'b0;
    if (ird && loc) begin
      rd_pending = 1'b1;
      rd_expect  = m_local.exists(int'(a[10:0])) ? m_local[int'(a[10:0])] : local_init(int'(a[10:0]));
    end else if (e_rden && ce) begin
      rd_pending = 1'b1;
      rd_expect  = m_ext.exists(int'(a)) ? m_ext[int'(a)] : ext_init(int'(a));
    end
    if (w && loc) m_local[int'(a[10:0])] = d;
    if (n > 0 && ce) begin
      m_ext[int'(wq[0][31:16])] = wq[0][15:0];
      void'(wq.pop_front());
    end
    if (w && !loc && n < WBD) wq.push_back({a, d});

    if ((w || r) && !e_stall)
      $display("txn %s addr=%h data=%h", w ? "wr" : "rd", a, w ? d : rd_expect);

    @(posedge clk);
    local_q = env_local.exists(int'(la)) ? env_local[int'(la)] : local_init(int'(la));
    if (lw) env_local[int'(la)] = lwd;
    memory_read_val = env_ext.exists(int'(ma)) ? env_ext[int'(ma)] : ext_init(int'(ma));
    if (mw) env_ext[int'(ma)] = mv;
    @(negedge clk);
  endtask

  task automatic idle(input logic ce);
    do_cycle(1'b0, 1'b0, 16'h0000, 16'h0000, ce);
  endtask

  task automatic drain();
    int guard = 0;
    while (wq.size() > 0 && guard < 100) begin
      idle(1'b1);
      guard++;
    end
    if (wq.size() > 0) begin
      checks++;
      $display("FAIL drain_bound: %0d entries left, required 0", wq.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic w, r, ce;
    logic [15:0] a, d;
    int kind, tries;

    reset = 1'b1; dwrite_en = 0; dread_en = 0; daddr = 0; ddata_out = 0; core_enable = 0;
    local_q = 0; memory_read_val = 0; rd_pending = 0; rd_expect = 0; m_stall = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wb_count", wb_count, 0);
    chk("rst_wb_empty", wb_empty, 1);
    chk("rst_core_request", core_request, 0);
    chk("rst_memory_wren", memory_wren, 0);
    chk("rst_memory_rden", memory_rden, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(1'b0);
    chk("post_rst_stall", obs_stall, 0);

    // Local write then read-back.
    do_cycle(1, 0, 16'h0010, 16'h1234, 0);
    chk("loc_wr_stall", obs_stall, 0);
    chk("loc_wr_wren", obs_lwren, 1);
    do_cycle(0, 1, 16'h0010, 16'h0000, 0);
    chk("loc_rd_stall", obs_stall, 0);
    idle(0);
    chk("loc_rd_data", obs_ddata, 16'h1234);

    // Fill the buffer with the bus held off; fifth write stalls.
    for (int i = 0; i < 4; i++) begin
      do_cycle(1, 0, 16'h8000 + 16'(i), 16'hA000 + 16'(i), 0);
      chk("fill_stall", obs_stall, 0);
    end
    do_cycle(1, 0, 16'h8004, 16'hA004, 0);
    chk("full_stall", obs_stall, 1);
    chk("full_count", obs_count, 4);
    do_cycle(1, 0, 16'h8004, 16'hA004, 1);
    chk("full_deq_stall", obs_stall, 1);
    chk("drain0_addr", obs_maddr, 16'h8000);
    do_cycle(1, 0, 16'h8004, 16'hA004, 1);
    chk("fifth_accept", obs_stall, 0);
    chk("drain1_addr", obs_maddr, 16'h8001);
    drain();

    // Read behind a posted write to the same address.
    do_cycle(1, 0, 16'h8000, 16'hBEEF, 0);
    do_cycle(0, 1, 16'h8000, 16'h0000, 0);
    chk("raw_stall_a", obs_stall, 1);
    chk("raw_rden_a", obs_rden, 0);
    do_cycle(0, 1, 16'h8000, 16'h0000, 1);
    chk("raw_stall_b", obs_stall, 1);
    chk("raw_wren_b", obs_wren, 1);
    chk("raw_rden_b", obs_rden, 0);
    do_cycle(0, 1, 16'h8000, 16'h0000, 1);
    chk("raw_stall_c", obs_stall, 0);
    chk("raw_rden_c", obs_rden, 1);
    idle(0);
    chk("raw_data", obs_ddata, 16'hBEEF);

    // External read with grant withheld for three cycles.
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 1, 16'h9000, 16'h0000, 0);
      chk("ext_rd_wait", obs_stall, 1);
    end
    do_cycle(0, 1, 16'h9000, 16'h0000, 1);
    chk("ext_rd_grant", obs_stall, 0);
    idle(0);
    chk("ext_rd_data", obs_ddata, 16'hCA5A);

    // Local write concurrent with a drain.
    do_cycle(1, 0, 16'h8100, 16'h7777, 0);
    do_cycle(1, 0, 16'h0020, 16'h5555, 1);
    chk("conc_lwren", obs_lwren, 1);
    chk("conc_mwren", obs_wren, 1);
    chk("conc_stall", obs_stall, 0);

    // Reset with three writes still buffered.
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 16'hC000 + 16'(i), 16'h1111, 0);
    idle(0);
    chk("pre_rst_count", obs_count, 3);
    reset = 1'b1; dwrite_en = 0; dread_en = 0; core_enable = 1;
    #1;
    chk("mid_rst_count", wb_count, 0);
    chk("mid_rst_request", core_request, 0);
    chk("mid_rst_wren", memory_wren, 0);
    wq.delete();
    rd_pending = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("post_rst_no_wr", obs_wren, 0);
    end

    // Randomized traffic; stalled requests are re-presented as a pipeline would.
    for (int i = 0; i < 1200; i++) begin
      kind = $urandom_range(0, 9);
      w = (kind inside {[0:3]}) || kind == 8;
      r = (kind inside {[4:7]}) || kind == 8;
      d = 16'($urandom);
      if (kind[0]) a = {2'b00, 3'($urandom), 7'd0, 4'($urandom)};
      else         a = {2'($urandom_range(1, 3)), 10'd0, 4'($urandom)};
      if (kind == 9) begin w = 0; r = 0; end
      tries = 0;
      do begin
        ce = ($urandom_range(0, 3) != 0);
        do_cycle(w, r, a, d, ce);
        tries++;
      end while (m_stall && tries < 64);
      if (m_stall) begin
        checks++;
        $display("FAIL stall_bound: still stalled after %0d cycles, required release", tries);
      end
    end
    drain();
    idle(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
